// File: rtl/ps2_kbd_rx_if.sv
// Bus between the PS/2 receiver and the game cores: raw pin inputs plus the
// decoded scan-code outputs.
interface ps2_kbd_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keyboard;
  logic       valid;
  logic       released;
  logic       extended;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keyboard, valid, released, extended, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keyboard, valid, released, extended, frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the pins, deframes
// device-to-host bytes and folds the F0/E0 prefixes into the scan-code flags.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          SUPPRESS_BREAK = 1'b1
) (
  input logic        clk,
  input logic        rst,
  ps2_kbd_rx_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity over the data byte and its parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic [1:0]    clk_sync_r, data_sync_r;
  logic [7:0]    filt_cnt_r;
  logic          filt_clk_r, filt_d_r;
  logic          fe_s, data_s, timeout_hit_s;

  state_t        state_r, state_s;
  logic [7:0]    shift_r, shift_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic          par_r, par_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic          brk_pend_r, brk_pend_s, ext_pend_r, ext_pend_s;
  logic [7:0]    keyboard_r, keyboard_s;
  logic          released_r, released_s, extended_r, extended_s;
  logic          valid_r, valid_s, frame_err_r, frame_err_s;

  // Two-flop synchronisers for both raw pins, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], bus.ps2_clk};
      data_sync_r <= {data_sync_r[0], bus.ps2_data};
    end
  end

  // Glitch filter: a new level must persist FILTER_LEN cycles to be adopted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_r <= 1'b1;
      filt_d_r   <= 1'b1;
      filt_cnt_r <= 8'd0;
    end else begin
      filt_d_r <= filt_clk_r;
      if (clk_sync_r[1] != filt_clk_r) begin
        if (filt_cnt_r == FILT_LAST) begin
          filt_clk_r <= clk_sync_r[1];
          filt_cnt_r <= 8'd0;
        end else begin
          filt_cnt_r <= filt_cnt_r + 8'd1;
        end
      end else begin
        filt_cnt_r <= 8'd0;
      end
    end
  end

  assign fe_s   = filt_d_r & ~filt_clk_r;
  assign data_s = data_sync_r[1];
  // A falling edge in the same cycle always beats the timeout.
  assign timeout_hit_s = (state_r != IDLE) && !fe_s && ((to_cnt_r + TW'(1)) == TO_LAST);

  // Next-state, deframing and prefix handling.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    par_s       = par_r;
    brk_pend_s  = brk_pend_r;
    ext_pend_s  = ext_pend_r;
    keyboard_s  = keyboard_r;
    released_s  = released_r;
    extended_s  = extended_r;
    valid_s     = 1'b0;
    frame_err_s = 1'b0;

    if (state_r == IDLE) begin
      to_cnt_s = {TW{1'b0}};
    end else if (fe_s) begin
      to_cnt_s = {TW{1'b0}};
    end else begin
      to_cnt_s = to_cnt_r + TW'(1);
    end

    case (state_r)
      IDLE: begin
        if (fe_s && !data_s) begin
          state_s   = DATA;
          bit_cnt_s = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (fe_s) begin
          shift_s   = {data_s, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = PARITY;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (fe_s) begin
          par_s   = data_s;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (fe_s) begin
          state_s = IDLE;
          if (data_s && odd_parity_ok(shift_r, par_r)) begin
            if (shift_r == 8'hF0) begin
              brk_pend_s = 1'b1;
            end else if (shift_r == 8'hE0) begin
              ext_pend_s = 1'b1;
            end else begin
              keyboard_s = shift_r;
              released_s = brk_pend_r;
              extended_s = ext_pend_r;
              brk_pend_s = 1'b0;
              ext_pend_s = 1'b0;
              valid_s    = ~(SUPPRESS_BREAK & brk_pend_r);
            end
          end else begin
            frame_err_s = 1'b1;
            brk_pend_s  = 1'b0;
            ext_pend_s  = 1'b0;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (timeout_hit_s) begin
      state_s     = IDLE;
      frame_err_s = 1'b1;
      brk_pend_s  = 1'b0;
      ext_pend_s  = 1'b0;
    end else begin
      frame_err_s = frame_err_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= 8'd0;
      bit_cnt_r   <= 3'd0;
      par_r       <= 1'b0;
      to_cnt_r    <= {TW{1'b0}};
      brk_pend_r  <= 1'b0;
      ext_pend_r  <= 1'b0;
      keyboard_r  <= 8'd0;
      released_r  <= 1'b0;
      extended_r  <= 1'b0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      par_r       <= par_s;
      to_cnt_r    <= to_cnt_s;
      brk_pend_r  <= brk_pend_s;
      ext_pend_r  <= ext_pend_s;
      keyboard_r  <= keyboard_s;
      released_r  <= released_s;
      extended_r  <= extended_s;
      valid_r     <= valid_s;
      frame_err_r <= frame_err_s;
    end
  end

  assign bus.keyboard  = keyboard_r;
  assign bus.valid     = valid_r;
  assign bus.released  = released_r;
  assign bus.extended  = extended_r;
  assign bus.frame_err = frame_err_r;

endmodule
